sha256_id_issue: RTL and testbench
==================================

// Module: sha256_id_issue
// PURPOSE
//  Transmit side of the SHA-2 ID interface: issues the per-block {id, last} stream consumed by
//  sha256_id_buf id_in. Sits on the message path upstream of the message builder; passes 512-bit
//  blocks through and tags every accepted block with the current packet ID. The ID increments
//  once per packet, and the ID record is buffered so the ID buffer may stall independently.
// PARAMETERS
//  DATA_W      512  message block width, passed through unchanged
//  ID_W        6    packet ID width; must match sha256_id_buf
//  FIFO_DEPTH  4    ID record FIFO depth, power of 2, >=2
//  ID_START    0    first ID issued after reset
// PORTS
//  clk            in   1       clock, rising edge
//  sync_rst       in   1       synchronous reset, active-high
//  en             in   1       block enable; low stalls all handshakes
//  data_in        in   DATA_W  upstream message block
//  data_in_last   in   1       final block of packet
//  data_in_valid  in   1       upstream valid
//  data_in_ready  out  1       upstream ready
//  data_out       out  DATA_W  block to message builder (combinational pass-through)
//  data_out_last  out  1       pass-through of data_in_last
//  data_out_valid out  1       downstream valid
//  data_out_ready in   1       downstream ready
//  id_out         out  ID_W    ID tag for one block (to sha256_id_buf id_in)
//  id_out_last    out  1       tagged block is final block of its packet
//  id_out_valid   out  1       ID record valid
//  id_out_ready   in   1       ID record accepted
//  status_id      out  ID_W    ID of the most recent packet whose last block was accepted
// BEHAVIOUR
//  - Reset (sync_rst=1 at posedge): FIFO emptied, cur_id<=ID_START, status_id<=0, id_out_valid=0
//    next cycle; id_out/id_out_last read 0 while empty. Reset wins over every simultaneous event.
//  - gate = en & ~fifo_full. data_in_ready = data_out_ready & gate; data_out_valid =
//    data_in_valid & gate. Accept = data_in_valid & data_in_ready. Full is used alone (no pop
//    look-ahead) so there is no ready path from id_out_ready to data_in_ready.
//  - On accept: push {cur_id, data_in_last}. If data_in_last: status_id<=cur_id and
//    cur_id<=cur_id+1 mod 2^ID_W (63 -> 0 for ID_W=6); else cur_id held.
//  - ID latency: record visible on id_out/id_out_valid the cycle after accept (registered FIFO).
//  - id_out side: valid = ~fifo_empty & en; pop on id_out_valid & id_out_ready. Data/last stable
//    while valid & ~ready. Records leave strictly in accept order.
//  - Same-cycle push and pop allowed when not full and not empty; count unchanged.
//  - Full: data_in_ready=0 until a pop completes; the pop cycle frees a slot for the next cycle.
//  - en=0: both ready outputs and both valid outputs low; FIFO, cur_id, status_id held.
//  - Reset mid-packet: partially tagged packet's records discarded; next accepted block is
//    tagged ID_START as the start of a new packet.
//  - No state machine beyond FIFO pointers; cur_id is the only packet-boundary state.
// STRUCTURE
//  - sha256_id_pkg: ID_W localparam, typedef struct packed {logic [ID_W-1:0] id; logic last;}
//    id_rec_t, shared with sha256_id_buf.
//  - Sub-module sha256_id_issue_fifo: sync FIFO of id_rec_t, FIFO_DEPTH entries, ptr+1-bit wrap
//    full/empty, same clk/sync_rst/en. Top holds pass-through gating, cur_id and status_id.
// TESTING
//  1. One 1-block packet, all readies=1 -> id_out=0,last=1 one cycle after accept; status_id=0.
//  2. Packets of 2,1,3 blocks -> id stream (0,0),(0,1),(1,1),(2,0),(2,0),(2,1); status_id ends 2.
//  3. id_out_ready=0, 6 blocks offered -> 4 accepted, data_in_ready=0; release -> 4 records in
//     order, remaining 2 accepted once slots free, no loss/duplication.
//  4. 65 single-block packets -> IDs 0..63 then 0; status_id=0 after the 65th.
//  5. sync_rst after block 1 of a 3-block packet -> id_out_valid=0 next cycle; next block id=0.
//  6. en=0 for 5 cycles mid-stream with valids high -> no handshakes, outputs held; resumes
//     exactly where stopped. Random stall/gap regression vs. reference model on top.

Source files
------------

// File: rtl/sha256_id_pkg.sv
// Shared types for the SHA-2 ID interface: packet ID width and the per-block ID record.
// Latency: none (types and helpers only).
// Backpressure: not applicable.
package sha256_id_pkg;

    localparam int ID_W = 6;

    // One tag per message block: owning packet ID and whether it closes the packet.
    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            last;
    } id_rec_t;

    localparam logic [ID_W-1:0] ID_ONE = {{(ID_W-1){1'b0}}, 1'b1};

    // Packet IDs wrap modulo 2^ID_W.
    function automatic logic [ID_W-1:0] id_next(input logic [ID_W-1:0] id);
        return id + ID_ONE;
    endfunction

endpackage

// File: rtl/sha256_id_issue_fifo.sv
// Synchronous FIFO of ID records; pointers carry one extra wrap bit to tell full from empty.
// Latency: a pushed record is visible on o_pop_dat the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored; i_en low freezes everything.
module sha256_id_issue_fifo
    import sha256_id_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    sync_rst,
    input  logic    i_en,
    input  logic    i_push,
    input  id_rec_t i_push_dat,
    input  logic    i_pop,
    output id_rec_t o_pop_dat,
    output logic    o_empty,
    output logic    o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    id_rec_t       r_mem [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_push = i_en & i_push & ~o_full;
    assign w_do_pop  = i_en & i_pop & ~o_empty;

    // Head record reads zero while empty so the output never shows stale entries.
    assign o_pop_dat = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

    // Pointer update; reset discards every stored record at once.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // Storage write; contents need no reset because empty masks the output.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_push_dat;
    end

endmodule

// File: rtl/sha256_id_issue.sv
// Passes message blocks through and queues one {packet ID, last} record per accepted block.
// Latency: data path combinational; ID record appears on id_out one cycle after acceptance.
// Backpressure: data_in_ready needs data_out_ready, en and a free record slot (full only, no pop look-ahead).
module sha256_id_issue
    import sha256_id_pkg::*;
#(
    parameter int              DATA_W     = 512,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [ID_W-1:0] ID_START   = '0
) (
    input  logic              clk,
    input  logic              sync_rst,
    input  logic              en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_in_last,
    input  logic              data_in_valid,
    output logic              data_in_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_last,
    output logic              data_out_valid,
    input  logic              data_out_ready,
    output logic [ID_W-1:0]   id_out,
    output logic              id_out_last,
    output logic              id_out_valid,
    input  logic              id_out_ready,
    output logic [ID_W-1:0]   status_id
);

    logic            w_gate;
    logic            w_accept;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    id_rec_t         w_push_rec;
    id_rec_t         w_head_rec;
    logic [ID_W-1:0] r_cur_id;
    logic [ID_W-1:0] r_status_id;

    // Gating uses full alone so id_out_ready never reaches data_in_ready combinationally.
    assign w_gate         = en & ~w_full;
    assign data_in_ready  = data_out_ready & w_gate;
    assign data_out_valid = data_in_valid & w_gate;
    assign data_out       = data_in;
    assign data_out_last  = data_in_last;
    assign w_accept       = data_in_valid & data_in_ready;

    assign w_push_rec.id   = r_cur_id;
    assign w_push_rec.last = data_in_last;

    assign id_out_valid = ~w_empty & en;
    assign w_pop        = id_out_valid & id_out_ready;
    assign id_out       = w_head_rec.id;
    assign id_out_last  = w_head_rec.last;
    assign status_id    = r_status_id;

    sha256_id_issue_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .sync_rst   (sync_rst),
        .i_en       (en),
        .i_push     (w_accept),
        .i_push_dat (w_push_rec),
        .i_pop      (w_pop),
        .o_pop_dat  (w_head_rec),
        .o_empty    (w_empty),
        .o_full     (w_full)
    );

    // Packet ID advances after the last block of a packet is accepted; status records the closed ID.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_cur_id    <= ID_START;
            r_status_id <= '0;
        end else if (w_accept && data_in_last) begin
            r_status_id <= r_cur_id;
            r_cur_id    <= id_next(r_cur_id);
        end
    end

endmodule

// File: tb/tb_sha256_id_issue.sv
// Randomized and directed bench for sha256_id_issue against a queue-based reference model.
// Latency: model records become poppable the cycle after acceptance.
// Backpressure: model gates acceptance on en, data_out_ready and queue occupancy.
module tb_sha256_id_issue;
    import sha256_id_pkg::*;

    localparam int DATA_W = 512;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              sync_rst = 1'b0;
    logic              en = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              data_in_last = 1'b0;
    logic              data_in_valid = 1'b0;
    logic              data_in_ready;
    logic [DATA_W-1:0] data_out;
    logic              data_out_last;
    logic              data_out_valid;
    logic              data_out_ready = 1'b0;
    logic [ID_W-1:0]   id_out;
    logic              id_out_last;
    logic              id_out_valid;
    logic              id_out_ready = 1'b0;
    logic [ID_W-1:0]   status_id;

    always #5 clk = ~clk;

    sha256_id_issue #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH),
        .ID_START   ('0)
    ) dut (
        .clk            (clk),
        .sync_rst       (sync_rst),
        .en             (en),
        .data_in        (data_in),
        .data_in_last   (data_in_last),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_last  (data_out_last),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .id_out         (id_out),
        .id_out_last    (id_out_last),
        .id_out_valid   (id_out_valid),
        .id_out_ready   (id_out_ready),
        .status_id      (status_id)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: pending records in order, current packet ID, last closed ID.
    id_rec_t mq[$];
    id_rec_t plog[$];
    int      m_cur    = 0;
    int      m_status = 0;
    int      acc_cnt  = 0;

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got[63:0], exp[63:0]);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs to the model, then advance the model.
    task automatic step(input bit rst, input bit e, input bit iv, input bit il, input bit dor, input bit ior);
        bit      gate, exp_rdy, exp_ivld, acc, pop;
        id_rec_t head;
        id_rec_t rec;
        @(negedge clk);
        sync_rst       = rst;
        en             = e;
        data_in_valid  = iv;
        data_in_last   = il;
        data_out_ready = dor;
        id_out_ready   = ior;
        for (int k = 0; k < DATA_W / 32; k++) data_in[k*32 +: 32] = $urandom;
        #1;
        gate     = e && (mq.size() < DEPTH);
        exp_rdy  = dor && gate;
        exp_ivld = e && (mq.size() > 0);
        head     = (mq.size() > 0) ? mq[0] : '0;
        check_eq("in_ready",  data_in_ready,  exp_rdy);
        check_eq("out_valid", data_out_valid, iv && gate);
        check_eq("out_data",  data_out,       data_in);
        check_eq("out_last",  data_out_last,  il);
        check_eq("id_valid",  id_out_valid,   exp_ivld);
        check_eq("id_out",    id_out,         head.id);
        check_eq("id_last",   id_out_last,    head.last);
        check_eq("status_id", status_id,      m_status[ID_W-1:0]);
        acc = iv && exp_rdy;
        pop = exp_ivld && ior;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_cur    = 0;
            m_status = 0;
        end else begin
            if (pop) plog.push_back(mq.pop_front());
            if (acc) begin
                rec.id   = m_cur[ID_W-1:0];
                rec.last = il;
                mq.push_back(rec);
                acc_cnt++;
                if (il) begin
                    m_status = m_cur;
                    m_cur    = (m_cur + 1) % (1 << ID_W);
                end
            end
        end
    endtask

    task automatic do_reset();
        step(1, 1, 0, 0, 1, 1);
        plog.delete();
        acc_cnt = 0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 1, 1);
    endtask

    initial begin
        int id_e[6];
        int last_e[6];
        int n_before;
        int p_before;
        int lens[3];

        // Reset state
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 1);
        @(negedge clk);
        check_eq("rst_id_valid", id_out_valid, 1'b0);
        check_eq("rst_status",   status_id,    '0);
        do_reset();

        // 1: single one-block packet
        step(0, 1, 1, 1, 1, 1);
        check_eq("t1_acc", acc_cnt, 1);
        drain(2);
        check_eq("t1_n",      plog.size(), 1);
        check_eq("t1_rec",    (plog.size() > 0) ? plog[0] : '0, {6'd0, 1'b1});
        check_eq("t1_status", status_id, 0);

        // 2: packets of 2,1,3 blocks
        do_reset();
        lens = '{2, 1, 3};
        foreach (lens[p]) begin
            for (int b = 0; b < lens[p]; b++) step(0, 1, 1, (b == lens[p] - 1), 1, 1);
        end
        drain(3);
        id_e   = '{0, 0, 1, 2, 2, 2};
        last_e = '{0, 1, 1, 0, 0, 1};
        check_eq("t2_n", plog.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < plog.size()) begin
                check_eq("t2_id",   plog[i].id,   id_e[i]);
                check_eq("t2_last", plog[i].last, last_e[i]);
            end
        end
        check_eq("t2_status", status_id, 2);

        // 3: ID consumer stalled; FIFO fills at 4
        do_reset();
        for (int i = 0; i < 6; i++) step(0, 1, 1, 1, 1, 0);
        check_eq("t3_acc_full", acc_cnt, 4);
        @(negedge clk);
        check_eq("t3_in_ready", data_in_ready, 1'b0);
        for (int i = 0; i < 20 && acc_cnt < 6; i++) step(0, 1, 1, 1, 1, 1);
        check_eq("t3_acc_all", acc_cnt, 6);
        drain(6);
        check_eq("t3_n", plog.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < plog.size()) check_eq("t3_order", plog[i].id, i);

        // 4: 65 single-block packets wrap the ID
        do_reset();
        for (int i = 0; i < 65; i++) step(0, 1, 1, 1, 1, 1);
        drain(3);
        check_eq("t4_n", plog.size(), 65);
        if (plog.size() == 65) begin
            check_eq("t4_id63", plog[63].id, 63);
            check_eq("t4_wrap", plog[64].id, 0);
        end
        check_eq("t4_status", status_id, 0);

        // 5: reset in mid-packet discards records and restarts at ID 0
        do_reset();
        step(0, 1, 1, 1, 1, 1);
        step(0, 1, 1, 0, 1, 0);
        step(1, 1, 0, 0, 1, 0);
        plog.delete();
        @(negedge clk);
        check_eq("t5_valid_after_rst", id_out_valid, 1'b0);
        step(0, 1, 1, 0, 1, 1);
        drain(2);
        check_eq("t5_n",    plog.size(), 1);
        check_eq("t5_rec",  (plog.size() > 0) ? plog[0] : '1, {6'd0, 1'b0});

        // 6: en low with valids high holds everything
        do_reset();
        step(0, 1, 1, 0, 1, 0);
        step(0, 1, 1, 1, 1, 0);
        n_before = acc_cnt;
        p_before = plog.size();
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 1, 1);
        check_eq("t6_no_acc", acc_cnt, n_before);
        check_eq("t6_no_pop", plog.size(), p_before);
        step(0, 1, 1, 1, 1, 1);
        drain(4);
        check_eq("t6_n", plog.size(), 3);
        if (plog.size() == 3) begin
            check_eq("t6_r0", plog[0], {6'd0, 1'b0});
            check_eq("t6_r1", plog[1], {6'd0, 1'b1});
            check_eq("t6_r2", plog[2], {6'd1, 1'b1});
        end

        // Random stall/gap regression
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
                 $urandom_range(0, 1), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) != 0), $urandom_range(0, 1));
        end
        drain(6);
        check_eq("rand_drained", id_out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
